// File: rtl/io_stream_server.sv
// I/O responder beside the processor: per-port sample FIFOs feed io_in on read strobes,
// and a result FIFO captures io_out on write strobes and drains it as a valid/ready stream.
module io_stream_server #(
  parameter  int NUIOIN = 4,
  parameter  int NUIOOU = 4,
  parameter  int NBIN   = 13,
  parameter  int NBOUT  = 21,
  parameter  int FDEPTH = 8,
  localparam int HPW    = (NUIOIN > 1) ? $clog2(NUIOIN) : 1,
  localparam int RPW    = (NUIOOU > 1) ? $clog2(NUIOOU) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    h_valid,
  input  logic [HPW-1:0]          h_port,
  input  logic signed [NBIN-1:0]  h_data,
  output logic                    h_ready,
  input  logic [NUIOIN-1:0]       req_in,
  output logic signed [NBIN-1:0]  io_in,
  input  logic [NUIOOU-1:0]       out_en,
  input  logic signed [NBOUT-1:0] io_out,
  output logic                    r_valid,
  output logic [RPW-1:0]          r_port,
  output logic signed [NBOUT-1:0] r_data,
  input  logic                    r_ready,
  output logic [2:0]              err,
  input  logic                    clr_err
);

  localparam int AW = $clog2(FDEPTH);
  localparam int CW = AW + 1;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;
  typedef struct packed {
    logic [RPW-1:0]   port;
    logic [NBOUT-1:0] data;
  } res_t;

  // ---------------- input FIFOs ----------------
  logic signed [NBIN-1:0] in_mem [NUIOIN][FDEPTH];
  ptr_t                   in_wptr [NUIOIN];
  ptr_t                   in_rptr [NUIOIN];
  cnt_t                   in_cnt  [NUIOIN];
  logic [NUIOIN-1:0]      in_full, in_empty, in_push, in_pop;
  logic                   h_push;
  logic                   rd_any, rd_multi, rd_ok, rd_under;
  logic [HPW-1:0]         rd_sel;

  assign h_ready  = !in_full[h_port];
  assign h_push   = h_valid && h_ready;
  assign rd_any   = |req_in;
  assign rd_multi = |(req_in & (req_in - NUIOIN'(1)));
  assign rd_ok    = rd_any && !in_empty[rd_sel];
  assign rd_under = rd_any && in_empty[rd_sel];
  assign io_in    = rd_ok ? in_mem[rd_sel][in_rptr[rd_sel]] : '0;

  // NOTE: every always_comb output gets a default before any conditional assignment,
  // so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    rd_sel = '0;
    for (int i = NUIOIN - 1; i >= 0; i--)
      if (req_in[i]) rd_sel = HPW'(i);
  end

  always_comb begin
    in_full  = '0;
    in_empty = '0;
    in_push  = '0;
    in_pop   = '0;
    for (int p = 0; p < NUIOIN; p++) begin
      in_full[p]  = (in_cnt[p] == cnt_t'(FDEPTH));
      in_empty[p] = (in_cnt[p] == '0);
      in_push[p]  = h_push && (h_port == HPW'(p));
      in_pop[p]   = rd_ok && (rd_sel == HPW'(p));
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int p = 0; p < NUIOIN; p++) begin
        in_wptr[p] <= '0;
        in_rptr[p] <= '0;
        in_cnt[p]  <= '0;
      end
    end else begin
      for (int p = 0; p < NUIOIN; p++) begin
        if (in_push[p]) in_wptr[p] <= in_wptr[p] + ptr_t'(1);
        if (in_pop[p])  in_rptr[p] <= in_rptr[p] + ptr_t'(1);
        in_cnt[p] <= in_cnt[p] + cnt_t'(in_push[p]) - cnt_t'(in_pop[p]);
      end
    end
  end

  // NOTE: storage arrays carry no reset; pointers and counts define which entries are live.
  always_ff @(posedge clk) begin
    if (h_push) in_mem[h_port][in_wptr[h_port]] <= h_data;
  end

  // ---------------- result FIFO ----------------
  res_t           res_mem [FDEPTH];
  ptr_t           res_wptr, res_rptr;
  cnt_t           res_cnt, res_left;
  res_t           head_q, head_d, res_word;
  logic           wr_any, wr_multi, res_full, res_pop, res_push, res_drop;
  logic [RPW-1:0] wr_sel;

  always_comb begin
    wr_sel = '0;
    for (int i = NUIOOU - 1; i >= 0; i--)
      if (out_en[i]) wr_sel = RPW'(i);
  end

  assign wr_any   = |out_en;
  assign wr_multi = |(out_en & (out_en - NUIOOU'(1)));
  assign res_full = (res_cnt == cnt_t'(FDEPTH));
  assign r_valid  = (res_cnt != '0);
  assign res_pop  = r_valid && r_ready;
  assign res_push = wr_any && (!res_full || res_pop);
  assign res_drop = wr_any && res_full && !res_pop;
  assign res_word = '{port: wr_sel, data: io_out};
  assign res_left = res_cnt - cnt_t'(res_pop);

  // Head is a register so r_port/r_data hold their last value when the FIFO runs dry.
  always_comb begin
    head_d = head_q;
    if (res_left != '0)
      head_d = res_mem[res_rptr + ptr_t'(res_pop)];
    else if (res_push)
      head_d = res_word;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_wptr <= '0;
      res_rptr <= '0;
      res_cnt  <= '0;
      head_q   <= '0;
    end else begin
      if (res_push) res_wptr <= res_wptr + ptr_t'(1);
      if (res_pop)  res_rptr <= res_rptr + ptr_t'(1);
      res_cnt <= res_cnt + cnt_t'(res_push) - cnt_t'(res_pop);
      head_q  <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (res_push) res_mem[res_wptr] <= res_word;
  end

  assign r_port = head_q.port;
  assign r_data = head_q.data;

  // ---------------- sticky errors ----------------
  logic [2:0] err_set;
  assign err_set = {rd_multi || wr_multi, res_drop, rd_under};

  // A fresh error in the clearing cycle survives the clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err <= '0;
    else      err <= (clr_err ? 3'b000 : err) | err_set;
  end

endmodule

// File: tb/tb_io_stream_server.sv
// Scoreboard bench for io_stream_server: stimulus queues expected io_in / result words,
// a negedge monitor pops and compares them whenever the DUT presents a strobe or a result.
module tb_io_stream_server;

  typedef logic [12:0] smp_t;
  typedef logic [22:0] res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        h_valid;
  logic [1:0]  h_port;
  logic [12:0] h_data;
  logic        h_ready;
  logic [3:0]  req_in;
  logic [12:0] io_in;
  logic [3:0]  out_en;
  logic [20:0] io_out;
  logic        r_valid;
  logic [1:0]  r_port;
  logic [20:0] r_data;
  logic        r_ready;
  logic [2:0]  err;
  logic        clr_err;

  int   n_tests = 0;
  int   n_fail  = 0;
  smp_t exp_io[$];
  res_t exp_res[$];

  io_stream_server dut (
    .clk(clk), .rst(rst),
    .h_valid(h_valid), .h_port(h_port), .h_data(h_data), .h_ready(h_ready),
    .req_in(req_in), .io_in(io_in),
    .out_en(out_en), .io_out(io_out),
    .r_valid(r_valid), .r_port(r_port), .r_data(r_data), .r_ready(r_ready),
    .err(err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int port, input int val);
    h_valid = 1'b1;
    h_port  = 2'(port);
    h_data  = 13'(val);
    step();
    h_valid = 1'b0;
  endtask

  task automatic strobe(input logic [3:0] r, input int expv);
    req_in = r;
    exp_io.push_back(smp_t'(expv));
    step();
    req_in = '0;
  endtask

  task automatic capture(input logic [3:0] oe, input int port, input int val, input bit keep);
    out_en = oe;
    io_out = 21'(val);
    if (keep) exp_res.push_back({2'(port), 21'(val)});
    step();
    out_en = '0;
  endtask

  task automatic clear_err();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("err after clr_err", 64'(err), 64'(3'b000));
  endtask

  // Monitor: compares DUT outputs against the scoreboard queues mid-cycle.
  always @(negedge clk) begin
    if (rst && req_in != '0) begin
      if (exp_io.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL io_in: strobe with no expectation, got %0h", io_in);
      end else begin
        check("io_in", 64'(io_in), 64'(exp_io.pop_front()));
      end
    end
    if (rst && r_valid && r_ready) begin
      if (exp_res.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL result: unexpected word got %0h", {r_port, r_data});
      end else begin
        check("result {port,data}", 64'({r_port, r_data}), 64'(exp_res.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; h_valid = 1'b0; h_port = '0; h_data = '0; req_in = '0;
    out_en = '0; io_out = '0; r_ready = 1'b0; clr_err = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    step();
    check("reset h_ready", 64'(h_ready), 64'(1));
    check("reset r_valid", 64'(r_valid), 64'(0));
    check("reset io_in",   64'(io_in),   64'(0));
    check("reset err",     64'(err),     64'(3'b000));
    check("reset r_data",  64'({r_port, r_data}), 64'(0));

    // Ordered read on port 2, then underflow on the fourth strobe.
    push(2, 5); push(2, -7); push(2, 4095);
    strobe(4'b0100, 5); strobe(4'b0100, -7); strobe(4'b0100, 4095);
    check("no underflow yet", 64'(err), 64'(3'b000));
    strobe(4'b0100, 0);
    check("underflow err", 64'(err), 64'(3'b001));
    clear_err();

    // Push and pop on an empty port: underflow, pushed word kept.
    h_valid = 1'b1; h_port = 2'd3; h_data = 13'd77;
    strobe(4'b1000, 0);
    h_valid = 1'b0;
    check("empty push+pop err", 64'(err), 64'(3'b001));
    strobe(4'b1000, 77);
    clear_err();

    // Fill port 1; simultaneous push+pop on a full FIFO refuses the push.
    for (int i = 0; i < 8; i++) push(1, 100 + i);
    h_port = 2'd1; #1;
    check("h_ready full port", 64'(h_ready), 64'(0));
    h_port = 2'd0; #1;
    check("h_ready other port", 64'(h_ready), 64'(1));
    h_valid = 1'b1; h_port = 2'd1; h_data = 13'd999;
    strobe(4'b0010, 100);
    h_valid = 1'b0;
    check("h_ready after refused push", 64'(h_ready), 64'(1));
    for (int i = 1; i < 8; i++) strobe(4'b0010, 100 + i);
    check("seven words remained", 64'(err), 64'(3'b000));
    strobe(4'b0010, 0);
    check("refused word absent", 64'(err), 64'(3'b001));
    clear_err();

    // Capture path with one-cycle latency.
    out_en = 4'b0010; io_out = 21'h100000; #1;
    check("r_valid in strobe cycle", 64'(r_valid), 64'(0));
    capture(4'b0010, 1, -1048576, 1'b1);
    check("capture r_valid", 64'(r_valid), 64'(1));
    check("capture r_port",  64'(r_port),  64'(1));
    check("capture r_data",  64'(r_data),  64'(21'h100000));
    r_ready = 1'b1;
    step();
    r_ready = 1'b0;
    check("r_valid after pop", 64'(r_valid), 64'(0));

    // Overflow: nine captures into an 8-deep FIFO, then full+pop accepts.
    for (int i = 0; i < 9; i++) capture(4'(1 << (i % 4)), i % 4, 1000 + i, i < 8);
    check("overflow r_valid", 64'(r_valid), 64'(1));
    check("overflow err",     64'(err),     64'(3'b010));
    r_ready = 1'b1;
    capture(4'b1000, 3, 2000, 1'b1);
    repeat (8) step();
    r_ready = 1'b0;
    check("drained r_valid", 64'(r_valid), 64'(0));
    clear_err();

    // Multi-hot strobes: lowest index served, other port untouched.
    push(1, 33); push(3, 44);
    out_en = 4'b0110; io_out = 21'd55;
    exp_res.push_back({2'd1, 21'd55});
    strobe(4'b1010, 33);
    out_en = '0;
    check("multi-hot err", 64'(err), 64'(3'b100));
    strobe(4'b1000, 44);
    check("multi-hot capture port", 64'({r_valid, r_port}), 64'(3'b101));
    r_ready = 1'b1;
    step();
    r_ready = 1'b0;

    // Async reset mid-drain.
    capture(4'b0001, 0, 11, 1'b1);
    capture(4'b0010, 1, 22, 1'b1);
    capture(4'b0100, 2, 33, 1'b1);
    r_ready = 1'b1;
    step();
    #2;
    rst = 1'b0;
    #1;
    check("async reset r_valid", 64'(r_valid), 64'(0));
    check("async reset err",     64'(err),     64'(3'b000));
    check("async reset h_ready", 64'(h_ready), 64'(1));
    exp_res.delete();
    r_ready = 1'b0;
    step();
    @(negedge clk);
    rst = 1'b1;
    step();
    check("post reset r_valid", 64'(r_valid), 64'(0));
    check("post reset head",    64'({r_port, r_data}), 64'(0));
    check("io expectations consumed",     64'(exp_io.size()),  64'(0));
    check("result expectations consumed", 64'(exp_res.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/io_stream_server.md
Name: io_stream_server

Overview:
- Responder for the processor's decoded I/O strobes.
- Feeds host-loaded integer samples onto io_in when a one-hot req_in line fires.
- Captures io_out whenever a one-hot out_en line fires.
- Sits beside the processor top level: it drives that level's io_in and req_in consumer side, and absorbs its io_out/out_en. The host, testbench or DMA talks to it through valid/ready streams.

Parameters:
NUIOIN, 4, number of processor input ports (width of req_in)
NUIOOU, 4, number of processor output ports (width of out_en)
NBIN, 13, signed input sample width (io_in)
NBOUT, 21, signed output sample width (io_out)
FDEPTH, 8, entries per input FIFO and in result FIFO (power of 2, >=2)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
h_valid  in  1  host sample valid
h_port  in  clog2(NUIOIN)  target input port for host sample
h_data  in  NBIN  signed sample
h_ready  out  1  host sample accepted when h_valid&h_ready
req_in  in  NUIOIN  processor read strobes (one-hot expected)
io_in  out  NBIN  signed sample presented to processor
out_en  in  NUIOOU  processor write strobes (one-hot expected)
io_out  in  NBOUT  signed processor result
r_valid  out  1  result available
r_port  out  clog2(NUIOOU)  output port index of result
r_data  out  NBOUT  signed result
r_ready  in  1  result consumer ready
err  out  3  sticky flags: [0] underflow, [1] overflow, [2] multi-hot strobe
clr_err  in  1  synchronous clear of err

Behaviour:
- Reset (rst=0, async):
  - All FIFO pointers and counts cleared; err=0.
  - Outputs: h_ready=1, r_valid=0, io_in=0, r_port=0, r_data=0.
- Input FIFOs: one FIFO of depth FDEPTH per input port.
  - h_ready = !full[h_port], combinational.
  - A push writes h_data into FIFO h_port on the edge where h_valid&h_ready.
- Read path:
  - Selected port p = lowest set bit of req_in.
  - io_in = head of FIFO p, combinational and same cycle, so the processor samples it in the strobe cycle.
  - io_in=0 when req_in=0 or FIFO p is empty.
  - On the edge with req_in!=0: FIFO p pops if non-empty; if empty, no pop and err[0] is set.
  - More than one req_in bit set: only the lowest index is served and err[2] is set.
- Simultaneous host push and processor pop on the same port:
  - Both take effect; count is unchanged.
  - If the FIFO was empty, the pop underflows (err[0]) and the pushed word is stored.
  - A full FIFO stays not-ready that cycle; the push is not accepted even though a pop occurs.
- Write path:
  - Capture port q = lowest set bit of out_en.
  - On the edge with out_en!=0, {q, io_out} is pushed into the result FIFO.
  - If the result FIFO is full and not popping this cycle, the word is dropped and err[1] is set.
  - If the result FIFO is full and popping this cycle, the word is accepted.
  - Multi-hot out_en: lowest index captured, err[2] set.
- Result stream:
  - r_valid = result FIFO non-empty; r_port/r_data = head, registered storage, no bubble.
  - Pop on r_valid&r_ready.
  - Latency: a captured word is visible on r_valid one cycle after its out_en edge.
  - r_port/r_data hold their value while r_valid=0 (last head or reset value).
- Pointers wrap modulo FDEPTH; count range is 0..FDEPTH.
- err bits are sticky until clr_err=1 on an edge. A new error in the same cycle as clr_err wins, so the bit stays set.
- Reset mid-stream discards all buffered data and takes effect immediately, independent of clk.
- Arithmetic: samples are passed through untouched, no sign extension or scaling.

Test Plan:
- Reset then idle:
  - Hold rst=0 for 3 cycles, release -> h_ready=1, r_valid=0, io_in=0, err=000.
- Ordered read:
  - Push 5, -7, 4095 to port 2; then req_in=0100 for 3 cycles -> io_in = 5, -7, 4095 in successive strobe cycles; a 4th strobe gives io_in=0 and err=001.
- Full and simultaneous:
  - Push 8 words to port 1 -> h_ready=0 for h_port=1, while h_ready=1 for h_port=0.
  - Push plus pop on port 1 in the same cycle -> push refused, count 7.
- Capture path:
  - out_en=0010 with io_out=-1048576, r_ready=0 -> next cycle r_valid=1, r_port=1, r_data=-1048576.
  - Assert r_ready -> r_valid=0.
- Overflow:
  - 9 capture strobes with r_ready=0 -> 8 words retained, err[1]=1, and the 9th word is absent on drain.
  - clr_err -> err=000.
- Multi-hot and async reset:
  - req_in=1010 with port 1 holding 33 -> io_in=33, port 3 untouched, err[2]=1.
  - Assert rst mid-drain -> r_valid drops without waiting for a clock edge.
